// File: rtl/cpu_mem_pkg.sv
// ============================================================================
//  Module   : cpu_mem_pkg
//  Brief    : Shared widths, opcodes and FSM encodings for the CPU data RAM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

    localparam int MEM_ADDR_W   = 6;
    localparam int MEM_DATA_W   = 16;
    localparam int MEM_DEPTH    = 64;
    localparam int MEM_READ_LAT = 1;
    localparam int CNT_W        = 3;

    localparam logic [7:0] DUMP_OPCODE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2,
        DUMP     = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cpu_ram_responder_if.sv
// ============================================================================
//  Module   : cpu_ram_responder_if
//  Brief    : CPU <-> data-RAM bus bundle; resolves the shared data_ram bus.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface cpu_ram_responder_if
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) ();

    logic [ADDR_W-1:0] address_to_ram;
    logic              write_enable_to_ram;
    logic              read_enable_to_ram;
    logic              enable_ram_read;

    logic              cpu_oe;
    logic [DATA_W-1:0] cpu_wdata;
    logic              mem_oe;
    logic [DATA_W-1:0] mem_rdata;

    logic              rd_valid;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_valid;
    logic              dump_done;

    // Both bus drivers meet here; each side only asserts its enable when it owns the bus.
    wire  [DATA_W-1:0] data_ram;
    assign data_ram = mem_oe ? mem_rdata : (cpu_oe ? cpu_wdata : {DATA_W{1'bz}});

    modport slave (
        input  address_to_ram,
        input  write_enable_to_ram,
        input  read_enable_to_ram,
        input  enable_ram_read,
        input  data_ram,
        output mem_oe,
        output mem_rdata,
        output rd_valid,
        output dump_addr,
        output dump_data,
        output dump_valid,
        output dump_done
    );

    modport master (
        output address_to_ram,
        output write_enable_to_ram,
        output read_enable_to_ram,
        output enable_ram_read,
        output cpu_oe,
        output cpu_wdata,
        input  data_ram,
        input  mem_oe,
        input  rd_valid,
        input  dump_addr,
        input  dump_data,
        input  dump_valid,
        input  dump_done
    );

endinterface

`default_nettype wire

// File: rtl/cpu_ram_responder_ram_array.sv
// ============================================================================
//  Module   : ram_array
//  Brief    : DEPTH x DATA_W storage, sync write/clear, two async read ports.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_array
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok;
    logic              ok_a;
    logic              ok_b;

    // Addresses past DEPTH only exist when the address space is larger than the array.
    generate
        if (DEPTH >= (1 << ADDR_W)) begin : g_full
            assign wr_ok = we;
            assign ok_a  = 1'b1;
            assign ok_b  = 1'b1;
        end else begin : g_partial
            assign wr_ok = we && (32'(waddr) < DEPTH);
            assign ok_a  = (32'(raddr_a) < DEPTH);
            assign ok_b  = (32'(raddr_b) < DEPTH);
        end
    endgenerate

    assign rdata_a = ok_a ? mem_q[raddr_a] : '0;
    assign rdata_b = ok_b ? mem_q[raddr_b] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[waddr] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_ram_responder.sv
// ============================================================================
//  Module   : cpu_ram_responder
//  Brief    : Data-RAM responder: CPU writes, wait-stated reads, debug dump.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_ram_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int DEPTH    = MEM_DEPTH,
    parameter int READ_LAT = MEM_READ_LAT
) (
    input  logic                clk_main,
    input  logic                reset,
    cpu_ram_responder_if.slave  bus
);

    state_e            state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic              oe_q,         oe_d;
    logic              en_q,         en_d;
    logic [ADDR_W-1:0] dump_addr_q,  dump_addr_d;
    logic [DATA_W-1:0] dump_data_q,  dump_data_d;
    logic              dump_valid_q, dump_valid_d;
    logic              dump_done_q,  dump_done_d;

    logic              en_rise;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] dump_rd_data;

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk_main),
        .reset   (reset),
        .we      (bus.write_enable_to_ram),
        .waddr   (bus.address_to_ram),
        .wdata   (bus.data_ram),
        .raddr_a (addr_q),
        .rdata_a (rd_data),
        .raddr_b (dump_addr_d),
        .rdata_b (dump_rd_data)
    );

    assign en_rise = bus.enable_ram_read && !en_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        oe_d         = 1'b0;
        en_d         = bus.enable_ram_read;
        dump_addr_d  = '0;
        dump_valid_d = 1'b0;
        dump_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Dump takes priority: a missed edge is lost, a held read stays pending.
                if (en_rise) begin
                    state_d      = DUMP;
                    dump_valid_d = 1'b1;
                end else if (bus.read_enable_to_ram && !bus.write_enable_to_ram) begin
                    addr_d = bus.address_to_ram;
                    if (READ_LAT == 1) begin
                        state_d = RD_DRIVE;
                        oe_d    = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = CNT_W'(READ_LAT - 1);
                    end
                end
            end
            RD_WAIT: begin
                if (!bus.read_enable_to_ram) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RD_DRIVE;
                    oe_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_DRIVE: begin
                if (!bus.read_enable_to_ram || bus.write_enable_to_ram) begin
                    state_d = IDLE;
                end else begin
                    oe_d   = 1'b1;
                    addr_d = bus.address_to_ram;
                end
            end
            DUMP: begin
                if (dump_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = IDLE;
                    dump_done_d = 1'b1;
                end else begin
                    dump_valid_d = 1'b1;
                    dump_addr_d  = dump_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A write landing on the word being captured this edge is forwarded so the dump sees it.
    always_comb begin
        dump_data_d = '0;
        if (dump_valid_d) begin
            if (bus.write_enable_to_ram && (bus.address_to_ram == dump_addr_d)) begin
                dump_data_d = bus.data_ram;
            end else begin
                dump_data_d = dump_rd_data;
            end
        end
    end

    always_ff @(posedge clk_main) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            oe_q         <= 1'b0;
            en_q         <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            oe_q         <= oe_d;
            en_q         <= en_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
            dump_done_q  <= dump_done_d;
        end
    end

    assign bus.mem_oe     = oe_q;
    assign bus.mem_rdata  = rd_data;
    assign bus.rd_valid   = oe_q;
    assign bus.dump_addr  = dump_addr_q;
    assign bus.dump_data  = dump_data_q;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_done  = dump_done_q;

endmodule

`default_nettype wire
